// File: rtl/condicionador_pkg.sv
// Shared types and constants for the tank sensor conditioner.
// Holds the error and fill FSM state types, the tank level codes and
// the decoder that maps the debounced probe vector {H,M,L} to a level code.
package condicionador_pkg;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_SUSPEITO = 2'd1,
    ERR_ERRO     = 2'd2,
    ERR_RECUPERA = 2'd3
  } estado_erro_t;

  typedef enum logic {
    PARADO   = 1'b0,
    ENCHENDO = 1'b1
  } estado_ench_t;

  localparam logic [1:0] NIVEL_VAZIO = 2'b00;
  localparam logic [1:0] NIVEL_BAIXO = 2'b01;
  localparam logic [1:0] NIVEL_MEDIO = 2'b10;
  localparam logic [1:0] NIVEL_CHEIO = 2'b11;

  typedef struct packed {
    logic       valido;
    logic [1:0] codigo;
  } nivel_dec_t;

  // Probes wet from the bottom up form a thermometer code; anything else
  // means a stuck or failed probe.
  function automatic nivel_dec_t decodifica_nivel(input logic [2:0] hml);
    nivel_dec_t r;
    r.valido = 1'b1;
    case (hml)
      3'b000:  r.codigo = NIVEL_VAZIO;
      3'b001:  r.codigo = NIVEL_BAIXO;
      3'b011:  r.codigo = NIVEL_MEDIO;
      3'b111:  r.codigo = NIVEL_CHEIO;
      default: begin
        r.valido = 1'b0;
        r.codigo = NIVEL_VAZIO;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/debounce_sinal.sv
// Two-flop synchronizer followed by a debounce counter for one probe.
// Ports:
//   clk      system clock (rising edge)
//   rst      synchronous active-high reset
//   raw_i    asynchronous raw probe
//   deb_o    debounced level; changes DEB_CYCLES+2 cycles after a stable raw edge
//   pronto_o set once the first level after reset has been debounced
module debounce_sinal #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic deb_o,
  output logic pronto_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          v1_q, v2_q;
  logic          deb_q, deb_d;
  logic          pronto_q, pronto_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Until the first level is established the counter runs on every valid
  // sample, so the output after reset is itself a freshly debounced level
  // rather than the reset value taken on trust.
  always_comb begin
    deb_d    = deb_q;
    pronto_d = pronto_q;
    cnt_d    = '0;
    if (v2_q && (!pronto_q || (s2_q != deb_q))) begin
      if (cnt_q == CNT_MAX) begin
        deb_d    = s2_q;
        pronto_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      deb_q    <= 1'b0;
      pronto_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      v1_q     <= 1'b1;
      v2_q     <= v1_q;
      deb_q    <= deb_d;
      pronto_q <= pronto_d;
      cnt_q    <= cnt_d;
    end
  end

  assign deb_o    = deb_q;
  assign pronto_o = pronto_q;

endmodule

// File: rtl/condicionador_sensores.sv
// Tank level sensor conditioner and inlet valve controller.
// Debounces three level probes, encodes the tank level, flags
// inconsistent probe patterns and drives the inlet valve with hysteresis.
// Optional macro CONDICIONADOR_TIMEOUT_EN adds a sticky fill timeout
// (parameter FILL_TIMEOUT and output Timeout).
// Ports:
//   Clock, Reset          clock and synchronous active-high reset
//   H_raw, M_raw, L_raw   raw probes (1 = wet)
//   H, M, L               debounced probes
//   Nivel                 level code 00..11
//   Ve                    inlet valve command
//   E                     sensor/fill error flag
//   Timeout               sticky fill timeout (macro builds only)
module condicionador_sensores
  import condicionador_pkg::*;
#(
  parameter int DEB_CYCLES   = 16,
  parameter int ERR_CYCLES   = 8
`ifdef CONDICIONADOR_TIMEOUT_EN
  ,
  parameter int FILL_TIMEOUT = 1024
`endif
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       H_raw,
  input  logic       M_raw,
  input  logic       L_raw,
  output logic       H,
  output logic       M,
  output logic       L,
  output logic [1:0] Nivel,
  output logic       Ve,
  output logic       E
`ifdef CONDICIONADOR_TIMEOUT_EN
  ,
  output logic       Timeout
`endif
);

  localparam int ECW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
  localparam logic [ECW-1:0] ECNT_MAX = ECW'(ERR_CYCLES - 1);

  logic           pr_h, pr_m, pr_l, pronto;
  nivel_dec_t     dec;
  logic [1:0]     nivel_q, nivel_d;
  estado_erro_t   err_q, err_d;
  logic [ECW-1:0] ecnt_q, ecnt_d;
  logic           e_q, e_d;
  estado_ench_t   fill_q, fill_d;

`ifdef CONDICIONADOR_TIMEOUT_EN
  localparam int FCW = (FILL_TIMEOUT > 1) ? $clog2(FILL_TIMEOUT) : 1;
  localparam logic [FCW-1:0] FCNT_MAX = FCW'(FILL_TIMEOUT - 1);
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           tmo_q, tmo_d;
`endif

  debounce_sinal #(.DEB_CYCLES(DEB_CYCLES)) u_deb_h (
    .clk(Clock), .rst(Reset), .raw_i(H_raw), .deb_o(H), .pronto_o(pr_h));
  debounce_sinal #(.DEB_CYCLES(DEB_CYCLES)) u_deb_m (
    .clk(Clock), .rst(Reset), .raw_i(M_raw), .deb_o(M), .pronto_o(pr_m));
  debounce_sinal #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
    .clk(Clock), .rst(Reset), .raw_i(L_raw), .deb_o(L), .pronto_o(pr_l));

  assign pronto = pr_h & pr_m & pr_l;

  // An inconsistent probe pattern keeps the last good level on Nivel.
  assign dec   = decodifica_nivel({H, M, L});
  assign Nivel = dec.valido ? dec.codigo : nivel_q;
  assign nivel_d = Nivel;

  // Error FSM: ecnt_q counts consecutive invalid (SUSPEITO) or valid
  // (RECUPERA) samples, including the one that caused entry.
  always_comb begin
    err_d  = err_q;
    ecnt_d = ecnt_q;
    case (err_q)
      ERR_OK: begin
        if (!dec.valido) begin
          err_d  = ERR_SUSPEITO;
          ecnt_d = ECW'(1);
        end
      end
      ERR_SUSPEITO: begin
        if (dec.valido) begin
          err_d  = ERR_OK;
          ecnt_d = '0;
        end else if (ecnt_q == ECNT_MAX) begin
          err_d  = ERR_ERRO;
          ecnt_d = '0;
        end else begin
          ecnt_d = ecnt_q + 1'b1;
        end
      end
      ERR_ERRO: begin
        if (dec.valido) begin
          err_d  = ERR_RECUPERA;
          ecnt_d = ECW'(1);
        end
      end
      ERR_RECUPERA: begin
        if (!dec.valido) begin
          err_d  = ERR_ERRO;
          ecnt_d = '0;
        end else if (ecnt_q == ECNT_MAX) begin
          err_d  = ERR_OK;
          ecnt_d = '0;
        end else begin
          ecnt_d = ecnt_q + 1'b1;
        end
      end
      default: begin
        err_d  = ERR_OK;
        ecnt_d = '0;
      end
    endcase
  end

  // Fill FSM: levels 01 and 10 leave the valve as it is (hysteresis).
  // Filling waits for all probes to be freshly debounced after reset.
  always_comb begin
    fill_d = fill_q;
    case (fill_q)
      PARADO:   if ((Nivel == NIVEL_VAZIO) && !e_q && pronto) fill_d = ENCHENDO;
      ENCHENDO: if ((Nivel == NIVEL_CHEIO) || e_q) fill_d = PARADO;
      default:  fill_d = PARADO;
    endcase
`ifdef CONDICIONADOR_TIMEOUT_EN
    tmo_d  = tmo_q;
    fcnt_d = fcnt_q;
    if (fill_q == ENCHENDO) begin
      fcnt_d = fcnt_q + 1'b1;
      if (fcnt_q == FCNT_MAX) begin
        tmo_d  = 1'b1;
        fill_d = PARADO;
      end
    end else if (fill_d == ENCHENDO) begin
      fcnt_d = '0;
    end
    if (tmo_q) fill_d = PARADO;
`endif
  end

  always_comb begin
    e_d = (err_q == ERR_ERRO) || (err_q == ERR_RECUPERA);
`ifdef CONDICIONADOR_TIMEOUT_EN
    e_d = e_d || tmo_d;
`endif
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      nivel_q <= NIVEL_VAZIO;
      err_q   <= ERR_OK;
      ecnt_q  <= '0;
      e_q     <= 1'b0;
      fill_q  <= PARADO;
`ifdef CONDICIONADOR_TIMEOUT_EN
      fcnt_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      nivel_q <= nivel_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
      e_q     <= e_d;
      fill_q  <= fill_d;
`ifdef CONDICIONADOR_TIMEOUT_EN
      fcnt_q  <= fcnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign Ve = (fill_q == ENCHENDO);
  assign E  = e_q;
`ifdef CONDICIONADOR_TIMEOUT_EN
  assign Timeout = tmo_q;
`endif

endmodule

// File: tb/tb_condicionador_sensores.sv
// Bench for condicionador_sensores: reference model compared every cycle,
// a table of steady-state probe patterns, directed latency/corner sequences
// and randomized probe activity.
module tb_condicionador_sensores;

  localparam int DEB = 16;
  localparam int ERR = 8;
  localparam int FT  = 32;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       H_raw = 1'b0, M_raw = 1'b0, L_raw = 1'b0;
  logic       H, M, L, Ve, E;
  logic [1:0] Nivel;
`ifdef CONDICIONADOR_TIMEOUT_EN
  logic       Timeout;
`endif

  condicionador_sensores #(
    .DEB_CYCLES(DEB),
    .ERR_CYCLES(ERR)
`ifdef CONDICIONADOR_TIMEOUT_EN
    ,
    .FILL_TIMEOUT(FT)
`endif
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .H_raw(H_raw), .M_raw(M_raw), .L_raw(L_raw),
    .H(H), .M(M), .L(L), .Nivel(Nivel), .Ve(Ve), .E(E)
`ifdef CONDICIONADOR_TIMEOUT_EN
    ,
    .Timeout(Timeout)
`endif
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int         k;
  logic [2:0] raw_hist[$];
  logic [2:0] dq[$];
  logic [2:0] m_out;
  bit         m_ready;
  logic [1:0] m_hold;
  int         inv_run, val_run;
  bit         m_in_err, m_e, m_ve;
  int         fc;
  bit         m_tmo;

  function automatic bit valid_pat(input logic [2:0] p);
    int n;
    n = $countones(p);
    return p == (3'b111 >> (3 - n));
  endfunction

  function automatic logic [1:0] nivel_de(input logic [2:0] p, input logic [1:0] hold);
    return valid_pat(p) ? 2'($countones(p)) : hold;
  endfunction

  task automatic model_reset();
    k = 0;
    raw_hist.delete();
    dq.delete();
    m_out = 3'b000; m_ready = 0; m_hold = 2'd0;
    inv_run = 0; val_run = 0;
    m_in_err = 0; m_e = 0; m_ve = 0;
    fc = 0; m_tmo = 0;
  endtask

  task automatic model_step(input logic [2:0] raw);
    logic [2:0] out_o;
    logic [1:0] niv_o;
    bit rdy_o, err_o, e_o, ve_o, err_n, e_n, ve_n, all_diff;
    out_o = m_out;
    niv_o = nivel_de(m_out, m_hold);
    rdy_o = m_ready; err_o = m_in_err; e_o = m_e; ve_o = m_ve;
    k++;
    raw_hist.push_back(raw);
    // synchronized sample seen at edge k is the raw value of edge k-2
    if (k >= 3) dq.push_back(raw_hist[k-3]);
    if (!rdy_o) begin
      if (k == DEB + 2) begin
        m_out   = dq[dq.size()-1];
        m_ready = 1;
      end
    end else if (dq.size() >= DEB) begin
      for (int b = 0; b < 3; b++) begin
        all_diff = 1;
        for (int j = 1; j <= DEB; j++)
          if (dq[dq.size()-j][b] == out_o[b]) all_diff = 0;
        if (all_diff) m_out[b] = ~out_o[b];
      end
    end
    m_hold = niv_o;
    if (valid_pat(out_o)) begin val_run++; inv_run = 0; end
    else begin inv_run++; val_run = 0; end
    err_n = err_o ? (val_run < ERR) : (inv_run >= ERR);
    e_n   = err_o;
    ve_n  = ve_o ? !((niv_o == 2'd3) || e_o) : ((niv_o == 2'd0) && !e_o && rdy_o);
`ifdef CONDICIONADOR_TIMEOUT_EN
    if (ve_o && (fc == FT - 1)) m_tmo = 1;
    if (ve_o) fc++; else fc = 0;
    if (m_tmo) begin ve_n = 0; e_n = 1; end
`endif
    m_in_err = err_n; m_e = e_n; m_ve = ve_n;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [1:0] mn;
    mn = nivel_de(m_out, m_hold);
    chk("H",     4'(H),     4'(m_out[2]));
    chk("M",     4'(M),     4'(m_out[1]));
    chk("L",     4'(L),     4'(m_out[0]));
    chk("Nivel", 4'(Nivel), 4'(mn));
    chk("Ve",    4'(Ve),    4'(m_ve));
    chk("E",     4'(E),     4'(m_e));
`ifdef CONDICIONADOR_TIMEOUT_EN
    chk("Timeout", 4'(Timeout), 4'(m_tmo));
`endif
  endtask

  task automatic tick();
    @(posedge Clock);
    if (Reset) model_reset();
    else model_step({H_raw, M_raw, L_raw});
    #1;
    compare_all();
  endtask

  typedef struct {
    logic [2:0] raw;
    int         hold;
    logic [2:0] hml;
    logic [1:0] nivel;
    logic       ve;
    logic       e;
  } vec_t;

  vec_t       tab[12];
  int         r, hold;
  logic [2:0] p;

  initial begin
    tab[0]  = '{3'b000, 40, 3'b000, 2'd0, 1'b1, 1'b0};
    tab[1]  = '{3'b001, 40, 3'b001, 2'd1, 1'b1, 1'b0};
    tab[2]  = '{3'b011, 40, 3'b011, 2'd2, 1'b1, 1'b0};
    tab[3]  = '{3'b111, 40, 3'b111, 2'd3, 1'b0, 1'b0};
    tab[4]  = '{3'b011, 40, 3'b011, 2'd2, 1'b0, 1'b0};
    tab[5]  = '{3'b001, 40, 3'b001, 2'd1, 1'b0, 1'b0};
    tab[6]  = '{3'b000, 40, 3'b000, 2'd0, 1'b1, 1'b0};
    tab[7]  = '{3'b101, 40, 3'b101, 2'd0, 1'b0, 1'b1};
    tab[8]  = '{3'b111, 40, 3'b111, 2'd3, 1'b0, 1'b0};
    tab[9]  = '{3'b100, 40, 3'b100, 2'd3, 1'b0, 1'b1};
    tab[10] = '{3'b111, 40, 3'b111, 2'd3, 1'b0, 1'b0};
    tab[11] = '{3'b000, 40, 3'b000, 2'd0, 1'b1, 1'b0};

    model_reset();
    Reset = 1'b1;
    tick();
    tick();
    chk("rst_hml",   4'({H, M, L}), 4'd0);
    chk("rst_nivel", 4'(Nivel),     4'd0);
    chk("rst_ve",    4'(Ve),        4'd0);
    chk("rst_e",     4'(E),         4'd0);
    Reset = 1'b0;

`ifndef CONDICIONADOR_TIMEOUT_EN
    // valve opens exactly 2+DEB+1 cycles after reset release
    for (int i = 1; i <= DEB + 3; i++) begin
      tick();
      if (i == DEB + 2) chk("ve_before_fresh_empty", 4'(Ve), 4'd0);
      if (i == DEB + 3) begin
        chk("ve_after_fresh_empty", 4'(Ve), 4'd1);
        chk("nivel_empty", 4'(Nivel), 4'd0);
      end
    end

    // 10-cycle glitch on L is rejected
    L_raw = 1'b1;
    repeat (10) tick();
    L_raw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("glitch_L", 4'(L), 4'd0);
      chk("glitch_nivel", 4'(Nivel), 4'd0);
    end

    // raw edge to debounced edge latency is 2+DEB
    L_raw = 1'b1;
    repeat (DEB + 1) tick();
    chk("lat_L_early", 4'(L), 4'd0);
    tick();
    chk("lat_L_edge", 4'(L), 4'd1);
    chk("lat_ve_hyst", 4'(Ve), 4'd1);

    for (int i = 0; i < 12; i++) begin
      {H_raw, M_raw, L_raw} = tab[i].raw;
      repeat (tab[i].hold) tick();
      chk($sformatf("tab%0d_hml", i),   4'({H, M, L}), 4'(tab[i].hml));
      chk($sformatf("tab%0d_nivel", i), 4'(Nivel),     4'(tab[i].nivel));
      chk($sformatf("tab%0d_ve", i),    4'(Ve),        4'(tab[i].ve));
      chk($sformatf("tab%0d_e", i),     4'(E),         4'(tab[i].e));
    end

    // reset pulse while filling
    chk("fill_before_rst", 4'(Ve), 4'd1);
    Reset = 1'b1;
    tick();
    chk("midfill_rst_ve",    4'(Ve),        4'd0);
    chk("midfill_rst_hml",   4'({H, M, L}), 4'd0);
    chk("midfill_rst_nivel", 4'(Nivel),     4'd0);
    chk("midfill_rst_e",     4'(E),         4'd0);
    Reset = 1'b0;

    // error set/clear timing with H=1,L=0
    {H_raw, M_raw, L_raw} = 3'b111;
    repeat (40) tick();
    {H_raw, M_raw, L_raw} = 3'b100;
    repeat (DEB + 2 + ERR) tick();
    chk("err_set_early", 4'(E), 4'd0);
    tick();
    chk("err_set", 4'(E), 4'd1);
    chk("err_ve", 4'(Ve), 4'd0);
    {H_raw, M_raw, L_raw} = 3'b111;
    repeat (DEB + 2 + ERR) tick();
    chk("err_clr_early", 4'(E), 4'd1);
    tick();
    chk("err_clr", 4'(E), 4'd0);
`else
    // sticky fill timeout
    for (int i = 1; i <= DEB + 3 + FT; i++) begin
      tick();
      if (i == DEB + 2 + FT) begin
        chk("tmo_early", 4'(Timeout), 4'd0);
        chk("tmo_ve_on", 4'(Ve), 4'd1);
      end
    end
    chk("tmo_set", 4'(Timeout), 4'd1);
    chk("tmo_e",   4'(E),       4'd1);
    chk("tmo_ve",  4'(Ve),      4'd0);
    {H_raw, M_raw, L_raw} = 3'b111;
    repeat (40) tick();
    {H_raw, M_raw, L_raw} = 3'b000;
    repeat (40) tick();
    chk("tmo_sticky", 4'(Timeout), 4'd1);
    chk("tmo_e_sticky", 4'(E), 4'd1);
    Reset = 1'b1;
    tick();
    chk("tmo_rst", 4'(Timeout), 4'd0);
    Reset = 1'b0;
`endif

    // randomized probe activity against the model
    for (int s = 0; s < 150; s++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
      end else begin
        if (r < 60) begin
          case ($urandom_range(0, 3))
            0:       p = 3'b000;
            1:       p = 3'b001;
            2:       p = 3'b011;
            default: p = 3'b111;
          endcase
        end else begin
          p = 3'($urandom_range(0, 7));
        end
        {H_raw, M_raw, L_raw} = p;
        hold = ((r % 5) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 45);
        repeat (hold) tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/condicionador_sensores.md
CONDICIONADOR_SENSORES -- requirements
Module: condicionador_sensores

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles required before a debounced sensor output changes.
REQ-002 Parameter ERR_CYCLES, default 8: consecutive cycles of an invalid or valid level pattern before E sets or clears.
REQ-003 Parameter FILL_TIMEOUT, default 1024: maximum cycles in ENCHENDO before the fill times out; used only with CONDICIONADOR_TIMEOUT_EN.
REQ-004 Clock  input  1  single system clock; all logic on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 H_raw, M_raw, L_raw  input  1 each  asynchronous raw level probes (high/medium/low); 1 = probe wet.
REQ-007 H, M, L  output  1 each  debounced probe levels feeding the irrigation controller.
REQ-008 Nivel  output  2  tank level code.
REQ-009 Ve  output  1  inlet valve command.
REQ-010 E  output  1  sensor/fill error flag.
REQ-011 Timeout  output  1  sticky fill-timeout flag; present only with CONDICIONADOR_TIMEOUT_EN.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer.
REQ-013 Debounce: per-signal counter; counter advances while the synchronized sample differs from the output and returns to 0 on any match.
REQ-014 Debounced output SHALL toggle when the counter reaches DEB_CYCLES-1; raw edge to output latency is exactly 2+DEB_CYCLES cycles.
REQ-015 Nivel encodes {H,M,L}: 000->00, 001->01, 011->10, 111->11.
REQ-016 Any other {H,M,L} pattern is invalid; Nivel SHALL hold its previous value.
REQ-017 Error FSM states: OK, SUSPEITO, ERRO, RECUPERA.
REQ-018 Error FSM transitions:
- OK->SUSPEITO on an invalid pattern.
- SUSPEITO->ERRO after ERR_CYCLES consecutive invalid cycles; SUSPEITO->OK on any valid cycle.
- ERRO->RECUPERA on a valid pattern.
- RECUPERA->OK after ERR_CYCLES consecutive valid cycles; RECUPERA->ERRO on any invalid cycle.
REQ-019 E SHALL be 1 exactly in ERRO and RECUPERA (registered, set one cycle after the FSM enters ERRO).
REQ-020 Fill FSM states: PARADO, ENCHENDO.
REQ-021 Fill FSM transitions:
- PARADO->ENCHENDO when Nivel==00 and E==0.
- ENCHENDO->PARADO when Nivel==11 or E==1.
REQ-022 Ve SHALL be 1 only in ENCHENDO (registered).
REQ-023 Ve SHALL deassert the cycle after E rises, overriding a simultaneous fill condition.
REQ-024 Hysteresis: Nivel at 01 or 10 SHALL neither start nor stop filling.
REQ-025 Nivel==11 and E rising in the same cycle SHALL both yield PARADO, with no additional side effects.

Reset
REQ-026 On Reset, outputs SHALL take these values:
- H=M=L=0, Nivel=00, Ve=0, E=0, Timeout=0.
- Synchronizers and counters cleared.
- Error FSM = OK, fill FSM = PARADO.
REQ-027 Reset asserted mid-fill SHALL drop Ve on the next edge.
REQ-028 After Reset deasserts, the block SHALL restart debouncing from 0, so Ve can only reassert after a fresh debounced empty level.

Configuration
REQ-029 Macro CONDICIONADOR_TIMEOUT_EN defined: a fill counter clears on entering ENCHENDO and increments each ENCHENDO cycle.
REQ-030 With the macro defined, when the fill counter reaches FILL_TIMEOUT-1 the block SHALL set Timeout=1 and force E=1 and PARADO.
REQ-031 With the macro defined, Timeout and forced E are sticky until Reset; the error FSM cannot clear them.
REQ-032 Macro undefined: no fill counter, no Timeout port; filling is unbounded.

Structure
REQ-033 Package condicionador_pkg SHALL hold:
- Error and fill FSM state typedefs.
- Nivel code constants NIVEL_VAZIO=00, NIVEL_BAIXO=01, NIVEL_MEDIO=10, NIVEL_CHEIO=11.
REQ-034 Sub-module debounce_sinal (synchronizer plus debounce counter, parameter DEB_CYCLES) SHALL be instantiated three times.
REQ-035 Counter widths SHALL be $clog2 of their parameter.

Verification
REQ-036 Reset, all raw=0 held -> Nivel=00 and Ve=1 at cycle 2+16+1 after Reset release.
REQ-037 L_raw glitch of 10 cycles (DEB_CYCLES=16) -> L stays 0, Nivel unchanged.
REQ-038 Raise L,M,H in sequence while filling -> Ve stays 1 through Nivel 01 and 10, drops the cycle after Nivel=11.
REQ-039 Apply H=1,L=0 for 8 stable cycles -> E=1 and Ve=0.
REQ-040 Then restore valid 111 -> E clears after 8 further cycles.
REQ-041 With CONDICIONADOR_TIMEOUT_EN and FILL_TIMEOUT=32, hold all raw=0 -> Timeout=1, E=1, Ve=0 after 32 ENCHENDO cycles; both persist until Reset.
REQ-042 Reset pulse during ENCHENDO -> Ve=0 next cycle, all outputs at reset values.
